qpsk_sym_mixer: RTL and testbench

// - QPSK modulator back end. Consumes the I/Q carrier samples produced by the

---
 rtl/qpsk_sym_mixer.sv | 167 ++++++++++++++++
 tb/tb_qpsk_sym_mixer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_sym_mixer.sv
// QPSK symbol mixer: pairs serial bits into +/-1 I/Q symbols and forms
// mod_out = sI*carrier_I + sQ*carrier_Q through a two-stage pipeline.
module qpsk_sym_mixer #(
    parameter int SPS = 64,
    parameter int DW  = 16
) (
    input  logic                 clk_fs,
    input  logic                 rst,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    input  logic signed [DW-1:0] carrier_I,
    input  logic signed [DW-1:0] carrier_Q,
    output logic signed [DW:0]   mod_out,
    output logic                 mod_valid,
    output logic                 sym_strobe,
    output logic                 underrun
);

    localparam int            CW       = $clog2(SPS);
    localparam logic [CW-1:0] CNT_LAST = CW'(SPS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    // Sign application: bit 0 keeps the sample, bit 1 negates it. The most
    // negative sample cannot be negated within DW bits, so it saturates to the
    // most positive one; this keeps the sum range inside DW+1 bits.
    function automatic logic signed [DW:0] apply_sym(input logic neg,
                                                     input logic signed [DW-1:0] x);
        logic signed [DW:0] ext;
        ext = {x[DW-1], x};
        if (!neg) begin
            return ext;
        end
        if (x == {1'b1, {(DW-1){1'b0}}}) begin
            return {2'b00, {(DW-1){1'b1}}};
        end
        return -ext;
    endfunction

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         pcnt_q, pcnt_d;
    logic [1:0]         pbuf_q, pbuf_d;     // [0] = I bit, [1] = Q bit
    logic [1:0]         sym_q, sym_d;       // [0] = I sign, [1] = Q sign
    logic               bit_ready_q, bit_ready_d;
    logic               strobe_q, strobe_d;
    logic               underrun_q, underrun_d;
    logic               consume;

    logic signed [DW:0] term_i_p1_q, term_i_p1_d;
    logic signed [DW:0] term_q_p1_q, term_q_p1_d;
    logic               vld_p1_q, vld_p1_d;
    logic signed [DW:0] mod_p2_q, mod_p2_d;
    logic               vld_p2_q, vld_p2_d;

    // Symbol FSM, pair buffer and bit intake; a bit arriving while the pair is
    // consumed lands in the freshly emptied buffer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sym_d      = sym_q;
        pcnt_d     = pcnt_q;
        pbuf_d     = pbuf_q;
        strobe_d   = 1'b0;
        underrun_d = 1'b0;
        consume    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pcnt_q == 2'd2) begin
                    consume = 1'b1;
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (pcnt_q == 2'd2) begin
                        consume = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (consume) begin
            sym_d    = pbuf_q;
            strobe_d = 1'b1;
            pcnt_d   = 2'd0;
        end
        if (bit_valid && bit_ready_q) begin
            if (pcnt_d == 2'd0) begin
                pbuf_d[0] = bit_in;
                pcnt_d    = 2'd1;
            end else begin
                pbuf_d[1] = bit_in;
                pcnt_d    = 2'd2;
            end
        end
        bit_ready_d = (pcnt_d != 2'd2);
    end

    // Control registers
    always_ff @(posedge clk_fs or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pcnt_q      <= 2'd0;
            pbuf_q      <= 2'b00;
            sym_q       <= 2'b00;
            bit_ready_q <= 1'b0;
            strobe_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pcnt_q      <= pcnt_d;
            pbuf_q      <= pbuf_d;
            sym_q       <= sym_d;
            bit_ready_q <= bit_ready_d;
            strobe_q    <= strobe_d;
            underrun_q  <= underrun_d;
        end
    end

    // Datapath next values: signed terms (zero outside RUN), then their sum
    always_comb begin
        term_i_p1_d = '0;
        term_q_p1_d = '0;
        if (state_q == RUN) begin
            term_i_p1_d = apply_sym(sym_q[0], carrier_I);
            term_q_p1_d = apply_sym(sym_q[1], carrier_Q);
        end
        vld_p1_d = (state_q == RUN);
        mod_p2_d = term_i_p1_q + term_q_p1_q;
        vld_p2_d = vld_p1_q;
    end

    // Stage 1 -> stage 2 pipeline registers
    always_ff @(posedge clk_fs or posedge rst) begin
        if (rst) begin
            term_i_p1_q <= '0;
            term_q_p1_q <= '0;
            vld_p1_q    <= 1'b0;
            mod_p2_q    <= '0;
            vld_p2_q    <= 1'b0;
        end else begin
            term_i_p1_q <= term_i_p1_d;
            term_q_p1_q <= term_q_p1_d;
            vld_p1_q    <= vld_p1_d;
            mod_p2_q    <= mod_p2_d;
            vld_p2_q    <= vld_p2_d;
        end
    end

    assign bit_ready  = bit_ready_q;
    assign mod_out    = mod_p2_q;
    assign mod_valid  = vld_p2_q;
    assign sym_strobe = strobe_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_qpsk_sym_mixer.sv
// Scoreboard bench for qpsk_sym_mixer with SPS=4, DW=16.
module tb_qpsk_sym_mixer;

    localparam int SPS = 4;
    localparam int DW  = 16;

    logic                 clk_fs = 1'b0;
    logic                 rst    = 1'b1;
    logic                 bit_in = 1'b0;
    logic                 bit_valid = 1'b0;
    logic                 bit_ready;
    logic signed [DW-1:0] carrier_I = '0;
    logic signed [DW-1:0] carrier_Q = '0;
    logic signed [DW:0]   mod_out;
    logic                 mod_valid;
    logic                 sym_strobe;
    logic                 underrun;

    qpsk_sym_mixer #(.SPS(SPS), .DW(DW)) dut (
        .clk_fs    (clk_fs),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .carrier_I (carrier_I),
        .carrier_Q (carrier_Q),
        .mod_out   (mod_out),
        .mod_valid (mod_valid),
        .sym_strobe(sym_strobe),
        .underrun  (underrun)
    );

    always #5 clk_fs = ~clk_fs;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    // monitor-owned counters
    int cyc = 0, n_strobe = 0, n_under = 0, n_valid = 0, n_rise = 0;
    int cyc_under = 0, cyc_vfall = 0;
    logic prev_valid = 1'b0;

    // main-owned snapshots
    int s_strobe, s_under, s_valid, s_rise;
    int stalls = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: pops an expected sample for every valid output
    initial begin
        int e;
        forever begin
            @(negedge clk_fs);
            cyc++;
            if (sym_strobe) n_strobe++;
            if (underrun) begin
                n_under++;
                cyc_under = cyc;
            end
            if (mod_valid) begin
                n_valid++;
                if (!prev_valid) n_rise++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: got mod_out=%0d, required no valid sample", mod_out);
                end else begin
                    e = exp_q.pop_front();
                    check("mod_out", int'(mod_out), e);
                end
            end else if (prev_valid) begin
                cyc_vfall = cyc;
            end
            prev_valid = mod_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b);
        int t = 0;
        @(negedge clk_fs);
        bit_in    = b;
        bit_valid = 1'b1;
        while (!bit_ready && t < 100) begin
            @(negedge clk_fs);
            t++;
        end
        stalls += t;
        if (t >= 100) check("bit_ready_timeout", 0, 1);
        @(posedge clk_fs);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic run_pair(input logic bi, input logic bq, input int e);
        send_bit(bi);
        send_bit(bq);
        repeat (SPS) exp_q.push_back(e);
    endtask

    task automatic snap();
        s_strobe = n_strobe;
        s_under  = n_under;
        s_valid  = n_valid;
        s_rise   = n_rise;
    endtask

    task automatic drain_check(input string tag, input int strobes, input int valids,
                               input int unders);
        repeat (SPS + 8) @(negedge clk_fs);
        check({tag, "_strobes"}, n_strobe - s_strobe, strobes);
        check({tag, "_valid_cycles"}, n_valid - s_valid, valids);
        check({tag, "_underruns"}, n_under - s_under, unders);
        check({tag, "_valid_runs"}, n_rise - s_rise, 1);
        check({tag, "_idle_mod_out"}, int'(mod_out), 0);
        check({tag, "_idle_mod_valid"}, int'(mod_valid), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mod_out"}, int'(mod_out), 0);
        check({tag, "_mod_valid"}, int'(mod_valid), 0);
        check({tag, "_sym_strobe"}, int'(sym_strobe), 0);
        check({tag, "_underrun"}, int'(underrun), 0);
    endtask

    initial begin
        // reset with random activity on the inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_fs);
            bit_valid = 1'($urandom_range(1));
            bit_in    = 1'($urandom_range(1));
            carrier_I = DW'($urandom);
            carrier_Q = DW'($urandom);
            check_reset_outputs("reset");
        end
        @(negedge clk_fs);
        bit_valid = 1'b0;
        rst       = 1'b0;
        @(posedge clk_fs);
        #1;
        check("reset_bit_ready_after_release", int'(bit_ready), 1);

        // bits 0,0 -> +I +Q
        carrier_I = 16'sd1000;
        carrier_Q = 16'sd2000;
        snap();
        run_pair(1'b0, 1'b0, 3000);
        drain_check("sym00", 1, SPS, 1);
        check("underrun_to_valid_low", cyc_vfall - cyc_under, 2);

        // bits 1,0 -> -I +Q
        snap();
        run_pair(1'b1, 1'b0, 1000);
        drain_check("sym10", 1, SPS, 1);

        // bits 1,1 on the most negative carrier -> saturated negation
        carrier_I = -16'sd32768;
        carrier_Q = -16'sd32768;
        snap();
        run_pair(1'b1, 1'b1, 65534);
        drain_check("sym11_sat", 1, SPS, 1);

        // back-pressure: four pairs offered continuously, symbols back to back
        carrier_I = 16'sd1000;
        carrier_Q = 16'sd2000;
        snap();
        stalls = 0;
        run_pair(1'b0, 1'b0, 3000);
        run_pair(1'b1, 1'b0, 1000);
        run_pair(1'b0, 1'b1, -1000);
        run_pair(1'b1, 1'b1, -3000);
        check("backpressure_stalled", int'(stalls > 0), 1);
        drain_check("b2b", 4, 4 * SPS, 1);

        // reset mid-symbol with one stale bit buffered
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        @(posedge clk_fs);
        #1;
        rst = 1'b1;
        exp_q.delete();
        repeat (3) begin
            @(negedge clk_fs);
            check_reset_outputs("midreset");
        end
        rst = 1'b0;
        @(posedge clk_fs);
        #1;
        check("midreset_bit_ready_after_release", int'(bit_ready), 1);
        snap();
        run_pair(1'b1, 1'b1, -3000);
        drain_check("after_midreset", 1, SPS, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
